// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory access unit (master) and an SRAM-style port (slave).
// The master issues req/addr/wdata/strobes; the slave answers with addr_ok/data_ok/rdata.
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: drives the req/addr_ok/data_ok data bus, aligns/extends loads, builds store
// strobes, flags misaligned accesses and stalls the pipeline while a transfer is in flight.
module mem_access_unit #(
  parameter bit ADDR_MAP_EN = 1'b1,
  parameter bit RDATA_HOLD  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [3:0]                memop_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  input  logic                      flush_i,
  mem_access_unit_if.master         bus,
  output logic [31:0]               rdata_o,
  output logic                      done_o,
  output logic                      stall_o,
  output logic                      adel_o,
  output logic                      ades_o,
  output logic [31:0]               badvaddr_o
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LBU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LHU = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        wr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [3:0]  op_reg;
  logic [1:0]  off_reg;
  logic [31:0] rdata_reg;

  logic        is_load, is_store, is_half, is_word;
  logic        misaligned, idle, launch, capture;
  logic [1:0]  size_dec;
  logic [3:0]  strb_byte, strb_half, wstrb_dec;
  logic [31:0] wdata_dec, phys_addr, load_ext;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (memop_i)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default:       ;
    endcase
  end

  assign misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
  assign idle       = (state_reg == S_IDLE);
  // Address errors are reported even under flush so CP0 still sees the faulting op.
  assign adel_o     = idle & valid_i & is_load & misaligned;
  assign ades_o     = idle & valid_i & is_store & misaligned;
  assign badvaddr_o = (adel_o | ades_o) ? addr_i : 32'h0;
  assign launch     = idle & valid_i & (is_load | is_store) & ~misaligned & ~flush_i;

  assign size_dec  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
  assign phys_addr = (ADDR_MAP_EN && addr_i[31:30] == 2'b10) ? {3'b000, addr_i[28:0]} : addr_i;
  assign wdata_dec = is_word ? wdata_i : (is_half ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}});

  // Per-lane strobe selects and read-data byte lanes (little-endian).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign strb_byte[gi] = (addr_i[1:0] == LANE);
    assign strb_half[gi] = (addr_i[1] == LANE[1]);
    assign lane[gi]      = bus.data_rdata[8*gi +: 8];
  end

  assign wstrb_dec = !is_store ? 4'b0000 : (is_word ? 4'b1111 : (is_half ? strb_half : strb_byte));
  assign byte_sel  = lane[off_reg];
  assign half_sel  = off_reg[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    load_ext = bus.data_rdata;
    case (op_reg)
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h0, byte_sel};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0, half_sel};
      default: load_ext = bus.data_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE:  if (launch) state_next = S_REQ;
      S_REQ: begin
        if (bus.data_addr_ok && bus.data_data_ok) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end else if (bus.data_addr_ok) begin
          state_next = S_WAIT;
        end else if (flush_i) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end else if (flush_i) begin
          state_next = S_DRAIN;
        end
      end
      // An accepted request must still see its data_ok before the bus is reused.
      S_DRAIN: if (bus.data_data_ok) state_next = S_IDLE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= 32'h0;
      size_reg  <= 2'd0;
      wr_reg    <= 1'b0;
      wdata_reg <= 32'h0;
      wstrb_reg <= 4'b0000;
      op_reg    <= 4'b0000;
      off_reg   <= 2'b00;
      rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        addr_reg  <= phys_addr;
        size_reg  <= size_dec;
        wr_reg    <= is_store;
        wdata_reg <= wdata_dec;
        wstrb_reg <= wstrb_dec;
        op_reg    <= memop_i;
        off_reg   <= addr_i[1:0];
      end
      if (capture && !wr_reg) rdata_reg <= load_ext;
    end
  end

  assign bus.data_req   = (state_reg == S_REQ);
  assign bus.data_wr    = wr_reg;
  assign bus.data_size  = size_reg;
  assign bus.data_addr  = addr_reg;
  assign bus.data_wdata = wdata_reg;
  assign bus.data_wstrb = wstrb_reg;

  assign done_o  = (state_reg == S_DONE);
  assign stall_o = launch | (state_reg == S_REQ) | (state_reg == S_WAIT) | (state_reg == S_DRAIN);
  assign rdata_o = (RDATA_HOLD || (done_o && !wr_reg)) ? rdata_reg : 32'h0;

endmodule
